data_mem_arbiter: RTL and testbench

Two-requester arbiter and command sequencer sharing the single-port `data_mem` between the processor core's load/store path and a DMA/loader port. It sits between those requesters and `data_mem`, and it registers the winning request into a one-cycle memory command stage. Read data is routed back to the owner of that stage. The core has fixed priority, and a starvation counter guarantees DMA progress. DMA can lock the memory for bursts.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/data_mem_arbiter_if.sv | 66 ++++++
 rtl/arb_starve_ctr.sv | 50 +++++
 rtl/data_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and default widths for the data memory arbiter.
//                owner_e tags which requester owns the registered memory
//                command so that read data is routed back correctly.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int MEM_ARB_AW = 8;   // matches Data_address width
    localparam int MEM_ARB_DW = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/data_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter_if
//  Description : Bundles the core request port, the DMA request port and the
//                data_mem command/return signals.
//                slave  : arbiter view (takes requests, drives grants/command)
//                master : environment view (requesters plus data_mem)
//  Ports       : core_*  - core load/store handshake and read return
//                dma_*   - DMA/loader handshake, lock and read return
//                mem_*   - registered memory command and combinational rdata
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = MEM_ARB_AW,
    parameter int DW = MEM_ARB_DW
) ();

    // Core port
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_stall;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;

    // DMA port
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_lock;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_rdata;

    // data_mem side
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output mem_rdata
    );

endinterface : data_mem_arbiter_if
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ============================================================================
//  Module      : arb_starve_ctr
//  Description : Saturating loss counter. Counts up on inc until it reaches
//                MAX and stays there; clr returns it to zero and wins over inc.
//  Ports       : CLK, reset_n (async, active-low)
//                inc    - count one more loss
//                clr    - clear the count
//                at_max - count equals MAX
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic CLK,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int            W     = $clog2(MAX + 1);
    localparam logic [W-1:0]  C_MAX = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == C_MAX);

endmodule : arb_starve_ctr
`default_nettype wire

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_arbiter
//  Description : Two-requester arbiter for the single-port data_mem. The core
//                has fixed priority; a starvation counter forces a DMA win
//                after MAX_WAIT consecutive contested losses, and DMA may lock
//                the memory across consecutive grants. The winner is
//                registered into a one-cycle command stage and read data is
//                returned to the owner of that stage.
//  Ports       : CLK     - clock, rising edge
//                reset_n - asynchronous active-low reset
//                bus     - data_mem_arbiter_if.slave (core, DMA, data_mem)
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = MEM_ARB_AW,
    parameter int DW       = MEM_ARB_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              reset_n,
    data_mem_arbiter_if.slave bus
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          lock_st_q,   lock_st_d;
    owner_e        owner_q,     owner_d;
    logic [AW-1:0] mem_addr_q,  mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          mem_rd_en_q, mem_rd_en_d;
    logic          mem_wr_en_q, mem_wr_en_d;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    logic dma_at_max;
    logic dma_wins;
    logic core_gnt;
    logic dma_gnt;
    logic wait_inc;
    logic wait_clr;

    always_comb begin
        // DMA wins when uncontested, or when contested but either locked
        // or starved; otherwise any core request takes the slot.
        dma_wins = bus.dma_req & (~bus.core_req | lock_st_q | dma_at_max);
        // Grants are held low for as long as reset is asserted.
        dma_gnt  = reset_n & dma_wins;
        core_gnt = reset_n & bus.core_req & ~dma_wins;
        wait_inc = bus.dma_req & ~dma_gnt;
        wait_clr = dma_gnt | ~bus.dma_req;
    end

    arb_starve_ctr #(
        .MAX     (MAX_WAIT)
    ) u_starve_ctr (
        .CLK     (CLK),
        .reset_n (reset_n),
        .inc     (wait_inc),
        .clr     (wait_clr),
        .at_max  (dma_at_max)
    );

    // ------------------------------------------------------------------
    // Lock tracking: set after a locked DMA grant, dropped as soon as DMA
    // releases the lock or stops requesting.
    // ------------------------------------------------------------------
    always_comb begin
        lock_st_d = lock_st_q;
        if (!bus.dma_lock || !bus.dma_req) begin
            lock_st_d = 1'b0;
        end else if (dma_gnt) begin
            lock_st_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Command stage next state. Address and write data hold when idle so
    // the memory address bus does not toggle needlessly.
    // ------------------------------------------------------------------
    always_comb begin
        owner_d     = OWN_NONE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        if (dma_gnt) begin
            owner_d     = OWN_DMA;
            mem_addr_d  = bus.dma_addr;
            mem_wdata_d = bus.dma_wdata;
            mem_rd_en_d = ~bus.dma_we;
            mem_wr_en_d = bus.dma_we;
        end else if (core_gnt) begin
            owner_d     = OWN_CORE;
            mem_addr_d  = bus.core_addr;
            mem_wdata_d = bus.core_wdata;
            mem_rd_en_d = ~bus.core_we;
            mem_wr_en_d = bus.core_we;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            lock_st_q   <= 1'b0;
            owner_q     <= OWN_NONE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
        end else begin
            lock_st_q   <= lock_st_d;
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.core_gnt    = core_gnt;
    assign bus.dma_gnt     = dma_gnt;
    assign bus.core_stall  = bus.core_req & ~core_gnt;

    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.mem_wr_en   = mem_wr_en_q;

    // data_mem read is combinational, so the data for the command issued
    // this cycle is already on mem_rdata; only the valid is steered.
    assign bus.core_rvalid = (owner_q == OWN_CORE) & mem_rd_en_q;
    assign bus.dma_rvalid  = (owner_q == OWN_DMA)  & mem_rd_en_q;
    assign bus.core_rdata  = bus.mem_rdata;
    assign bus.dma_rdata   = bus.mem_rdata;

endmodule : data_mem_arbiter
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_arbiter
//  Description : Directed self-checking bench for data_mem_arbiter with a
//                behavioural data_mem (combinational read, clocked write).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;
    import mem_arb_pkg::*;

    logic CLK;
    logic reset_n;

    int checks = 0;
    int errors = 0;

    data_mem_arbiter_if #(.AW(8), .DW(8)) bus ();

    data_mem_arbiter #(
        .AW       (8),
        .DW       (8),
        .MAX_WAIT (4)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural data_mem with a bench-side preload port.
    logic [7:0] mem [256];
    logic       pre_we;
    logic [7:0] pre_addr;
    logic [7:0] pre_data;

    always @(posedge CLK) begin
        if (pre_we)             mem[pre_addr]     <= pre_data;
        else if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem[bus.mem_addr];

    // Start of a new cycle: just after the rising edge.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Middle of the current cycle: sampling point.
    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic idle_inputs();
        bus.core_req = 1'b0; bus.core_we = 1'b0; bus.core_addr = 8'h00; bus.core_wdata = 8'h00;
        bus.dma_req  = 1'b0; bus.dma_we  = 1'b0; bus.dma_addr  = 8'h00; bus.dma_wdata  = 8'h00;
        bus.dma_lock = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        cyc();
        pre_we = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.core_req = 1'b1;
        bus.dma_req  = 1'b1;
        mid();
        checks++; if (bus.core_gnt !== 1'b0) begin errors++; $display("FAIL reset_core_gnt: got %0b want 0", bus.core_gnt); end
        checks++; if (bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_dma_gnt: got %0b want 0", bus.dma_gnt); end
        checks++; if (bus.mem_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got rd=%0b wr=%0b want 0/0", bus.mem_rd_en, bus.mem_wr_en); end
        checks++; if (bus.core_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got core=%0b dma=%0b want 0/0", bus.core_rvalid, bus.dma_rvalid); end
        checks++; if (bus.mem_addr !== 8'h00 || bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h want 00/00", bus.mem_addr, bus.mem_wdata); end
        checks++; if (dut.owner_q !== OWN_NONE) begin errors++; $display("FAIL reset_owner: got %0d want 0", dut.owner_q); end
        idle_inputs();
        @(negedge CLK);
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_core_read();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h10;
        mid();
        checks++; if (bus.core_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL core_read_gnt: got core=%0b dma=%0b want 1/0", bus.core_gnt, bus.dma_gnt); end
        checks++; if (bus.core_stall !== 1'b0) begin errors++; $display("FAIL core_read_stall: got %0b want 0", bus.core_stall); end
        cyc();
        bus.core_req = 1'b0;
        mid();
        checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL core_read_en: got rd=%0b wr=%0b want 1/0", bus.mem_rd_en, bus.mem_wr_en); end
        checks++; if (bus.mem_addr !== 8'h10) begin errors++; $display("FAIL core_read_addr: got %h want 10", bus.mem_addr); end
        checks++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 8'hA5) begin errors++; $display("FAIL core_read_data: got v=%0b d=%h want 1/a5", bus.core_rvalid, bus.core_rdata); end
        checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL core_read_dma_rvalid: got %0b want 0", bus.dma_rvalid); end
        cyc();
        mid();
        checks++; if (bus.core_rvalid !== 1'b0 || bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL core_read_done: got v=%0b rd=%0b want 0/0", bus.core_rvalid, bus.mem_rd_en); end
        cyc();
    endtask

    // Both requesters held: core wins four times, then the starved DMA wins.
    task automatic test_contention();
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h40;
        for (int k = 0; k < 5; k++) begin
            logic exp_dma;
            exp_dma = (k == 4);
            bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'(k);
            mid();
            checks++; if (bus.dma_gnt !== exp_dma || bus.core_gnt !== !exp_dma) begin errors++; $display("FAIL contention_gnt[%0d]: got core=%0b dma=%0b want %0b/%0b", k, bus.core_gnt, bus.dma_gnt, !exp_dma, exp_dma); end
            checks++; if (bus.core_stall !== exp_dma) begin errors++; $display("FAIL contention_stall[%0d]: got %0b want %0b", k, bus.core_stall, exp_dma); end
            checks++; if (dut.u_starve_ctr.cnt_q !== 3'(k)) begin errors++; $display("FAIL contention_wait[%0d]: got %0d want %0d", k, dut.u_starve_ctr.cnt_q, k); end
            cyc();
        end
        idle_inputs();
        mid();
        checks++; if (dut.u_starve_ctr.cnt_q !== 3'd0) begin errors++; $display("FAIL contention_wait_after: got %0d want 0", dut.u_starve_ctr.cnt_q); end
        checks++; if (bus.dma_rvalid !== 1'b1 || bus.core_rvalid !== 1'b0 || bus.mem_addr !== 8'h40) begin errors++; $display("FAIL contention_dma_cmd: got dv=%0b cv=%0b addr=%h want 1/0/40", bus.dma_rvalid, bus.core_rvalid, bus.mem_addr); end
        cyc();
    endtask

    // DMA withdraws after two losses: the count clears without a grant.
    task automatic test_dma_drop();
        bus.dma_req = 1'b1; bus.dma_addr = 8'h41;
        bus.core_req = 1'b1; bus.core_addr = 8'h05;
        cyc();
        cyc();
        bus.dma_req = 1'b0;
        mid();
        checks++; if (dut.u_starve_ctr.cnt_q !== 3'd2) begin errors++; $display("FAIL drop_wait_before: got %0d want 2", dut.u_starve_ctr.cnt_q); end
        checks++; if (bus.core_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL drop_gnt: got core=%0b dma=%0b want 1/0", bus.core_gnt, bus.dma_gnt); end
        cyc();
        idle_inputs();
        mid();
        checks++; if (dut.u_starve_ctr.cnt_q !== 3'd0) begin errors++; $display("FAIL drop_wait_after: got %0d want 0", dut.u_starve_ctr.cnt_q); end
        cyc();
    endtask

    // DMA write then core read of the same address in the next cycle.
    task automatic test_forward();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h20; bus.dma_wdata = 8'h3C;
        mid();
        checks++; if (bus.dma_gnt !== 1'b1 || bus.core_gnt !== 1'b0) begin errors++; $display("FAIL fwd_dma_gnt: got dma=%0b core=%0b want 1/0", bus.dma_gnt, bus.core_gnt); end
        cyc();
        bus.dma_req = 1'b0; bus.dma_we = 1'b0;
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h20;
        mid();
        checks++; if (bus.core_gnt !== 1'b1) begin errors++; $display("FAIL fwd_core_gnt: got %0b want 1", bus.core_gnt); end
        checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_rd_en !== 1'b0 || bus.mem_addr !== 8'h20 || bus.mem_wdata !== 8'h3C) begin errors++; $display("FAIL fwd_write_cmd: got wr=%0b rd=%0b addr=%h wd=%h want 1/0/20/3c", bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, bus.mem_wdata); end
        checks++; if (bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL fwd_dma_rvalid: got %0b want 0", bus.dma_rvalid); end
        cyc();
        bus.core_req = 1'b0;
        mid();
        checks++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 8'h3C) begin errors++; $display("FAIL fwd_read_data: got v=%0b d=%h want 1/3c", bus.core_rvalid, bus.core_rdata); end
        cyc();
    endtask

    // Core then DMA in consecutive cycles with no bubble.
    task automatic test_back_to_back();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h10;
        mid();
        checks++; if (bus.core_gnt !== 1'b1) begin errors++; $display("FAIL b2b_core_gnt: got %0b want 1", bus.core_gnt); end
        cyc();
        bus.core_req = 1'b0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h20;
        mid();
        checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL b2b_dma_gnt: got %0b want 1", bus.dma_gnt); end
        checks++; if (bus.core_rvalid !== 1'b1 || bus.core_rdata !== 8'hA5) begin errors++; $display("FAIL b2b_core_data: got v=%0b d=%h want 1/a5", bus.core_rvalid, bus.core_rdata); end
        cyc();
        bus.dma_req = 1'b0;
        mid();
        checks++; if (bus.dma_rvalid !== 1'b1 || bus.dma_rdata !== 8'h3C || bus.core_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_dma_data: got dv=%0b d=%h cv=%0b want 1/3c/0", bus.dma_rvalid, bus.dma_rdata, bus.core_rvalid); end
        cyc();
    endtask

    // Locked DMA burst of three holds off a requesting core.
    task automatic test_lock();
        bus.dma_req = 1'b1; bus.dma_lock = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 8'h50;
        mid();
        checks++; if (bus.dma_gnt !== 1'b1) begin errors++; $display("FAIL lock_first_gnt: got %0b want 1", bus.dma_gnt); end
        cyc();
        bus.core_req = 1'b1; bus.core_we = 1'b0; bus.core_addr = 8'h11;
        for (int k = 1; k < 3; k++) begin
            bus.dma_addr = 8'h50 + 8'(k);
            mid();
            checks++; if (bus.dma_gnt !== 1'b1 || bus.core_gnt !== 1'b0 || bus.core_stall !== 1'b1) begin errors++; $display("FAIL lock_burst[%0d]: got dma=%0b core=%0b stall=%0b want 1/0/1", k, bus.dma_gnt, bus.core_gnt, bus.core_stall); end
            checks++; if (dut.lock_st_q !== 1'b1) begin errors++; $display("FAIL lock_state[%0d]: got %0b want 1", k, dut.lock_st_q); end
            cyc();
        end
        bus.dma_req = 1'b0; bus.dma_lock = 1'b0;
        mid();
        checks++; if (bus.core_gnt !== 1'b1 || bus.dma_gnt !== 1'b0) begin errors++; $display("FAIL lock_core_after: got core=%0b dma=%0b want 1/0", bus.core_gnt, bus.dma_gnt); end
        checks++; if (bus.dma_rvalid !== 1'b1 || bus.mem_addr !== 8'h52) begin errors++; $display("FAIL lock_last_cmd: got v=%0b addr=%h want 1/52", bus.dma_rvalid, bus.mem_addr); end
        cyc();
        bus.core_req = 1'b0;
        mid();
        checks++; if (dut.lock_st_q !== 1'b0) begin errors++; $display("FAIL lock_cleared: got %0b want 0", dut.lock_st_q); end
        cyc();
    endtask

    // Reset lands while a DMA write command is on the memory bus.
    task automatic test_async_reset();
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 8'h30; bus.dma_wdata = 8'h77;
        cyc();
        idle_inputs();
        #2;
        checks++; if (bus.mem_wr_en !== 1'b1 || bus.mem_addr !== 8'h30) begin errors++; $display("FAIL arst_pre_cmd: got wr=%0b addr=%h want 1/30", bus.mem_wr_en, bus.mem_addr); end
        reset_n = 1'b0;
        #1;
        checks++; if (bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL arst_wr_en: got %0b want 0", bus.mem_wr_en); end
        checks++; if (dut.owner_q !== OWN_NONE) begin errors++; $display("FAIL arst_owner: got %0d want 0", dut.owner_q); end
        cyc();
        checks++; if (mem[8'h30] !== 8'h11) begin errors++; $display("FAIL arst_mem_unchanged: got %h want 11", mem[8'h30]); end
        @(negedge CLK);
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_idle();
        idle_inputs();
        for (int k = 0; k < 10; k++) begin
            mid();
            checks++; if (bus.mem_rd_en !== 1'b0 || bus.mem_wr_en !== 1'b0) begin errors++; $display("FAIL idle_en[%0d]: got rd=%0b wr=%0b want 0/0", k, bus.mem_rd_en, bus.mem_wr_en); end
            cyc();
        end
        mid();
        checks++; if (bus.core_rvalid !== 1'b0 || bus.dma_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid: got core=%0b dma=%0b want 0/0", bus.core_rvalid, bus.dma_rvalid); end
        checks++; if (dut.u_starve_ctr.cnt_q !== 3'd0) begin errors++; $display("FAIL idle_wait: got %0d want 0", dut.u_starve_ctr.cnt_q); end
        cyc();
    endtask

    initial begin
        pre_we = 1'b0; pre_addr = 8'h00; pre_data = 8'h00;
        reset_n = 1'b0;
        idle_inputs();
        test_reset();
        preload(8'h10, 8'hA5);
        preload(8'h20, 8'h00);
        preload(8'h30, 8'h11);
        test_core_read();
        test_contention();
        test_dma_drop();
        test_forward();
        test_back_to_back();
        test_lock();
        test_async_reset();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_data_mem_arbiter
`default_nettype wire
